// File: rtl/bk_pipe_adder.sv
// Purpose: pipelined Brent-Kung prefix adder/subtractor (A+B+cin or A-B) with carry-out and signed overflow.
// Latency: 3 register stages (PG, up-sweep, down-sweep+sum); result registered on the third edge counting the accepting edge.
// Backpressure: valid/ready per stage, bubbles collapse; in_ready drops only when all three stages hold data and out_ready=0.
module bk_pipe_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] add_1,
  input  logic [WIDTH-1:0] add_2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int LOG = $clog2(WIDTH);

  // ---------------- handshake chain ----------------
  logic s1_valid, s2_valid;
  logic s1_en, s2_en, s3_en;

  // A stage may load when it is empty or its current contents leave this cycle.
  assign s3_en    = ~out_valid | out_ready;
  assign s2_en    = ~s2_valid | s3_en;
  assign s1_en    = ~s1_valid | s2_en;
  assign in_ready = ~rst & s1_en;

  // ---------------- S1: bitwise propagate/generate ----------------
  logic [WIDTH-1:0] b_mod, p_in, g_in;
  logic             c0_in;
  logic [WIDTH-1:0] s1_p, s1_g;
  logic             s1_c0;

  assign b_mod = sub ? ~add_2 : add_2;
  assign c0_in = sub | cin;
  assign p_in  = add_1 ^ b_mod;
  assign g_in  = add_1 & b_mod;

  // Capture PG terms of an accepted operand pair; data holds while the stage is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_p  <= p_in;
        s1_g  <= g_in;
        s1_c0 <= c0_in;
      end
    end
  end

  // ---------------- S2: Brent-Kung up-sweep ----------------
  // Carry-in is folded into bit 0's generate so every group generate is a true carry.
  for (genvar l = 0; l <= LOG; l++) begin : g_up
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    if (l == 0) begin : g_base
      assign g = {s1_g[WIDTH-1:1], s1_g[0] | (s1_p[0] & s1_c0)};
      assign p = s1_p;
    end else begin : g_lvl
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (((i + 1) % (1 << l)) == 0) begin : g_node
          assign g[i] = g_up[l-1].g[i] | (g_up[l-1].p[i] & g_up[l-1].g[i - (1 << (l - 1))]);
          assign p[i] = g_up[l-1].p[i] & g_up[l-1].p[i - (1 << (l - 1))];
        end else begin : g_pass
          assign g[i] = g_up[l-1].g[i];
          assign p[i] = g_up[l-1].p[i];
        end
      end
    end
  end

  logic [WIDTH-1:0] s2_g, s2_p, s2_pb;
  logic             s2_c0;

  // Register group terms plus the bitwise propagate needed for the final sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_g  <= g_up[LOG].g;
        s2_p  <= g_up[LOG].p;
        s2_pb <= s1_p;
        s2_c0 <= s1_c0;
      end
    end
  end

  // ---------------- S3: Brent-Kung down-sweep and sum ----------------
  // Each node is combined at most once in the down-sweep, so its up-sweep
  // group propagate is still the right operand there.
  for (genvar d = 0; d < LOG; d++) begin : g_dn
    logic [WIDTH-1:0] g;
    if (d == 0) begin : g_base
      assign g = s2_g;
    end else begin : g_lvl
      localparam int DIST = 1 << (LOG - 1 - d);
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if ((((i + 1) % (2 * DIST)) == DIST) && (i >= 3 * DIST - 1)) begin : g_node
          assign g[i] = g_dn[d-1].g[i] | (s2_p[i] & g_dn[d-1].g[i - DIST]);
        end else begin : g_pass
          assign g[i] = g_dn[d-1].g[i];
        end
      end
    end
  end

  logic [WIDTH-1:0] carry_out_all;  // carry out of each bit position
  logic [WIDTH-1:0] carry_in_all;   // carry into each bit position
  logic             unused_p;

  assign carry_out_all = g_dn[LOG-1].g;
  assign carry_in_all  = {carry_out_all[WIDTH-2:0], s2_c0};
  assign unused_p      = ^s2_p;

  // Output register: only changes when S3 loads a valid result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (s3_en) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        sum  <= s2_pb ^ carry_in_all;
        cout <= carry_out_all[WIDTH-1];
        ovf  <= carry_out_all[WIDTH-1] ^ carry_out_all[WIDTH-2];
      end
    end
  end

endmodule

// File: tb/tb_bk_pipe_adder.sv
// Bench for bk_pipe_adder: directed vectors, streaming with random stalls, mid-flight reset,
// and a width sweep (4 exhaustive, 8/32/64 random) against an arithmetic reference.
module tb_bk_pipe_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- WIDTH=16 DUT ----------------
  logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] add_1, add_2, sum;

  bk_pipe_adder #(.WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .add_1(add_1), .add_2(add_2), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf));

  // ---------------- sweep DUTs ----------------
  logic        sw_rdy;
  logic        iv4, ir4, ci4, sb4, ov4, co4, of4;
  logic [3:0]  a4, b4, s4;
  logic        iv8, ir8, ci8, sb8, ov8, co8, of8;
  logic [7:0]  a8, b8, s8;
  logic        iv32, ir32, ci32, sb32, ov32, co32, of32;
  logic [31:0] a32, b32, s32;
  logic        iv64, ir64, ci64, sb64, ov64, co64, of64;
  logic [63:0] a64, b64, s64;

  bk_pipe_adder #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .add_1(a4), .add_2(b4),
    .cin(ci4), .sub(sb4), .out_valid(ov4), .out_ready(sw_rdy), .sum(s4), .cout(co4), .ovf(of4));
  bk_pipe_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .add_1(a8), .add_2(b8),
    .cin(ci8), .sub(sb8), .out_valid(ov8), .out_ready(sw_rdy), .sum(s8), .cout(co8), .ovf(of8));
  bk_pipe_adder #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .add_1(a32), .add_2(b32),
    .cin(ci32), .sub(sb32), .out_valid(ov32), .out_ready(sw_rdy), .sum(s32), .cout(co32), .ovf(of32));
  bk_pipe_adder #(.WIDTH(64)) u_w64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .add_1(a64), .add_2(b64),
    .cin(ci64), .sub(sb64), .out_valid(ov64), .out_ready(sw_rdy), .sum(s64), .cout(co64), .ovf(of64));

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic on w-bit operands; returns {ovf, cout, sum}.
  function automatic logic [65:0] ref_calc(input int w, input logic [63:0] a_i,
                                           input logic [63:0] b_i, input logic ci, input logic sb);
    logic [63:0] mask, a, b, r;
    logic [64:0] t;
    logic        co, ov, as, bs, rs;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    a = a_i & mask;
    b = b_i & mask;
    if (sb) begin
      r  = (a - b) & mask;
      co = (a >= b);
    end else begin
      t  = {1'b0, a} + {1'b0, b} + 65'(ci);
      r  = t[63:0] & mask;
      co = t[w];
    end
    as = a[w-1];
    bs = b[w-1];
    rs = r[w-1];
    ov = sb ? ((as != bs) && (rs != as)) : ((as == bs) && (rs != as));
    return {ov, co, r};
  endfunction

  // ---------------- WIDTH=16 scoreboard monitor ----------------
  logic [65:0] q16[$];
  int          cnt = 0;          // operands accepted but not yet delivered
  logic        mon_en = 1'b0;
  logic        stall_prev = 1'b0;
  logic [65:0] prev_out;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        check("in_ready_in_reset", 66'(in_ready), 66'(0));
        q16.delete();
        cnt = 0;
        stall_prev = 1'b0;
      end else begin
        check("in_ready", 66'(in_ready), 66'(!(cnt == 3 && !out_ready)));
        if (cnt == 0) check("no_stale_out", 66'(out_valid), 66'(0));
        if (stall_prev) begin
          check("stall_valid", 66'(out_valid), 66'(1));
          check("stall_data", {ovf, cout, 64'(sum)}, prev_out);
        end
        if (out_valid && out_ready) begin
          if (q16.size() == 0) check("spurious_out", 66'(out_valid), 66'(0));
          else begin
            check("result16", {ovf, cout, 64'(sum)}, q16.pop_front());
            cnt--;
          end
        end
        if (in_valid && in_ready) begin
          q16.push_back(ref_calc(16, 64'(add_1), 64'(add_2), cin, sub));
          cnt++;
        end
        stall_prev = out_valid && !out_ready;
        prev_out   = {ovf, cout, 64'(sum)};
      end
    end
  end

  // ---------------- sweep scoreboard monitor ----------------
  logic [65:0] q4[$], q8[$], q32[$], q64[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (ov4) begin
        if (q4.size() == 0) check("w4_spurious", 66'(ov4), 66'(0));
        else check("w4", {of4, co4, 64'(s4)}, q4.pop_front());
      end
      if (iv4 && ir4) q4.push_back(ref_calc(4, 64'(a4), 64'(b4), ci4, sb4));
      if (ov8) begin
        if (q8.size() == 0) check("w8_spurious", 66'(ov8), 66'(0));
        else check("w8", {of8, co8, 64'(s8)}, q8.pop_front());
      end
      if (iv8 && ir8) q8.push_back(ref_calc(8, 64'(a8), 64'(b8), ci8, sb8));
      if (ov32) begin
        if (q32.size() == 0) check("w32_spurious", 66'(ov32), 66'(0));
        else check("w32", {of32, co32, 64'(s32)}, q32.pop_front());
      end
      if (iv32 && ir32) q32.push_back(ref_calc(32, 64'(a32), 64'(b32), ci32, sb32));
      if (ov64) begin
        if (q64.size() == 0) check("w64_spurious", 66'(ov64), 66'(0));
        else check("w64", {of64, co64, 64'(s64)}, q64.pop_front());
      end
      if (iv64 && ir64) q64.push_back(ref_calc(64, a64, b64, ci64, sb64));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic rand_op16();
    add_1 = 16'($urandom);
    add_2 = 16'($urandom);
    cin   = 1'($urandom);
    sub   = 1'($urandom);
  endtask

  // One isolated operation: checks latency and the spec-given result.
  task automatic directed(input string tag, input logic [15:0] a_i, input logic [15:0] b_i,
                          input logic ci, input logic sb, input logic [15:0] e_sum,
                          input logic e_co, input logic e_ov);
    int lat;
    @(posedge clk); #1;
    add_1 = a_i; add_2 = b_i; cin = ci; sub = sb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 66'(lat), 66'(3));
    check({tag, "_result"}, {ovf, cout, 64'(sum)}, {e_ov, e_co, 48'd0, e_sum});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    int seen, sent, guard;
    logic acc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    add_1 = '0; add_2 = '0; cin = 1'b0; sub = 1'b0;
    sw_rdy = 1'b1;
    iv4 = 0; a4 = '0; b4 = '0; ci4 = 0; sb4 = 0;
    iv8 = 0; a8 = '0; b8 = '0; ci8 = 0; sb8 = 0;
    iv32 = 0; a32 = '0; b32 = '0; ci32 = 0; sb32 = 0;
    iv64 = 0; a64 = '0; b64 = '0; ci64 = 0; sb64 = 0;

    // Reset state
    @(posedge clk); #1;
    check("rst_out_valid", 66'(out_valid), 66'(0));
    check("rst_sum", 66'(sum), 66'(0));
    check("rst_cout", 66'(cout), 66'(0));
    check("rst_ovf", 66'(ovf), 66'(0));
    check("rst_in_ready", 66'(in_ready), 66'(0));
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1; mon_en = 1'b1;
    #1 check("in_ready_after_rst", 66'(in_ready), 66'(1));

    // Directed vectors
    directed("add_basic", 16'h1234, 16'h0F0F, 1'b0, 1'b0, 16'h2143, 1'b0, 1'b0);
    directed("add_ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Ten back-to-back operands, out_ready held: ten results on ten consecutive cycles
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      rand_op16();
      in_valid = 1'b1;
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("stream_throughput", 66'(seen), 66'(10));
    repeat (2) @(posedge clk);
    #1;

    // Random stalls on the output, random gaps on the input
    sent = 0; guard = 0;
    while (sent < 30 && guard < 2000) begin
      if (!in_valid && $urandom_range(3) != 0) begin
        rand_op16();
        in_valid = 1'b1;
      end
      out_ready = 1'($urandom);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      guard++;
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("stall_stream_sent", 66'(sent), 66'(30));
    out_ready = 1'b1;
    guard = 0;
    while (cnt != 0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("stall_stream_drain", 66'(cnt), 66'(0));

    // Fill the pipe under a stall, then reset mid-flight
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (!in_valid) begin
        rand_op16();
        in_valid = 1'b1;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    check("full_in_ready", 66'(in_ready), 66'(0));
    check("full_out_valid", 66'(out_valid), 66'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", 66'(out_valid), 66'(0));
    check("midrst_sum", 66'(sum), 66'(0));
    check("midrst_cout", 66'(cout), 66'(0));
    check("midrst_ovf", 66'(ovf), 66'(0));
    check("midrst_in_ready", 66'(in_ready), 66'(0));
    rst = 1'b0;
    out_ready = 1'b1;
    #1 check("midrst_in_ready_after", 66'(in_ready), 66'(1));
    repeat (6) @(posedge clk);
    #1;
    directed("post_rst", 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Width sweep: exhaustive for 4 bits, random for 8/32/64
    for (int i = 0; i < 10000; i++) begin
      if (i < 1024) begin
        iv4 = 1'b1; a4 = i[3:0]; b4 = i[7:4]; ci4 = i[8]; sb4 = i[9];
      end else begin
        iv4 = 1'b0;
      end
      iv8  = 1'b1; a8  = 8'($urandom);  b8  = 8'($urandom);  ci8  = 1'($urandom); sb8  = 1'($urandom);
      iv32 = 1'b1; a32 = $urandom;      b32 = $urandom;      ci32 = 1'($urandom); sb32 = 1'($urandom);
      iv64 = 1'b1; a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
      ci64 = 1'($urandom); sb64 = 1'($urandom);
      @(posedge clk); #1;
    end
    iv4 = 1'b0; iv8 = 1'b0; iv32 = 1'b0; iv64 = 1'b0;
    guard = 0;
    while ((q4.size() + q8.size() + q32.size() + q64.size()) != 0 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("w4_drain", 66'(q4.size()), 66'(0));
    check("w8_drain", 66'(q8.size()), 66'(0));
    check("w32_drain", 66'(q32.size()), 66'(0));
    check("w64_drain", 66'(q64.size()), 66'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
